// File: rtl/dmem_mmio_pkg.sv
// Shared address map, register bit positions and address decode for the data memory / MMIO block.
// Addresses outside the RAM window and the three device registers decode to REGION_NONE.
package dmem_mmio_pkg;

   localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_0008;

   localparam int STATUS_EMPTY_BIT = 4;
   localparam int STATUS_FULL_BIT  = 5;
   localparam int STATUS_OVF_BIT   = 6;

   localparam int CTRL_CLR_OVF_BIT = 0;
   localparam int CTRL_FLUSH_BIT   = 1;

   typedef enum logic [2:0] {
      REGION_RAM,
      REGION_TXDATA,
      REGION_STATUS,
      REGION_CTRL,
      REGION_NONE
   } region_e;

   function automatic region_e decodeRegion(input logic [31:0] addr, input logic [31:0] ramBytes);
      region_e r;
      r = REGION_NONE;
      if (addr < ramBytes)          r = REGION_RAM;
      else if (addr == ADDR_TXDATA) r = REGION_TXDATA;
      else if (addr == ADDR_STATUS) r = REGION_STATUS;
      else if (addr == ADDR_CTRL)   r = REGION_CTRL;
      return r;
   endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO feeding the transmit port: circular buffer with read/write pointers and an occupancy count.
// A push while full is refused even if a pop happens in the same cycle; flush and reset override everything.
module tx_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pushOk;
   logic             popOk;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rdPtr_q];
   assign pushOk  = push_i && !full_o;
   assign popOk   = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
         if (pushOk && !popOk)      count_d = count_q + CNT_W'(1);
         else if (popOk && !pushOk) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && pushOk) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped transmit FIFO: word RAM, TXDATA/STATUS/CTRL registers, sticky overflow flag.
// Reads are purely combinational and side-effect free; all state changes happen on stores.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    MemWriteM,
   input  logic [2*DATA_WIDTH-1:0] ALUOutM,
   input  logic [31:0]             WriteDataM,
   output logic [31:0]             ReadDataM,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   output logic                    tx_overflow
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

   logic [31:0]      addr;
   region_e          region;
   logic [IDX_W-1:0] ramIdx;
   logic [31:0]      ram_q [MEM_WORDS];
   logic             ctrlWr;
   logic             pushReq;
   logic             flushReq;
   logic [CNT_W-1:0] fifoCount;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             overflow_q, overflow_d;
   logic [31:0]      status;

   assign addr   = ALUOutM[31:0];
   assign region = decodeRegion(addr, RAM_BYTES);
   assign ramIdx = addr[IDX_W+1:2];

   if (2 * DATA_WIDTH > 32) begin : gAddrHi
      logic unusedAddrHi;
      assign unusedAddrHi = |ALUOutM[2*DATA_WIDTH-1:32];
   end

   always_ff @(posedge clk) begin
      if (!reset && MemWriteM && (region == REGION_RAM)) ram_q[ramIdx] <= WriteDataM;
   end

   assign ctrlWr   = MemWriteM && (region == REGION_CTRL);
   assign pushReq  = MemWriteM && (region == REGION_TXDATA);
   assign flushReq = ctrlWr && WriteDataM[CTRL_FLUSH_BIT];

   tx_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_txFifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (pushReq),
      .pop_i  (tx_ready),
      .flush_i(flushReq),
      .data_i (WriteDataM[7:0]),
      .head_o (tx_data),
      .count_o(fifoCount),
      .full_o (fifoFull),
      .empty_o(fifoEmpty)
   );

   assign tx_valid    = !fifoEmpty;
   assign tx_overflow = overflow_q;

   // Fullness is judged before any same-cycle pop, so a push against a full FIFO is always lost.
   always_comb begin
      overflow_d = overflow_q;
      if (ctrlWr && WriteDataM[CTRL_CLR_OVF_BIT]) overflow_d = 1'b0;
      else if (pushReq && fifoFull)               overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   always_comb begin
      status                   = '0;
      status[3:0]              = 4'(fifoCount);
      status[STATUS_EMPTY_BIT] = fifoEmpty;
      status[STATUS_FULL_BIT]  = fifoFull;
      status[STATUS_OVF_BIT]   = overflow_q;
   end

   always_comb begin
      ReadDataM = '0;
      case (region)
         REGION_RAM:    ReadDataM = ram_q[ramIdx];
         REGION_STATUS: ReadDataM = status;
         default:       ReadDataM = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM access, address map, FIFO ordering, overflow, flush and reset behaviour.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_dmem_mmio;

   localparam logic [31:0] TX   = 32'hFFFF_0000;
   localparam logic [31:0] STAT = 32'hFFFF_0004;
   localparam logic [31:0] CTRL = 32'hFFFF_0008;

   logic        clk;
   logic        reset;
   logic        MemWriteM;
   logic [63:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_overflow;

   int totalChecks = 0;
   int badChecks   = 0;

   dmem_mmio dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_overflow(tx_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Holds one bus cycle across a rising edge, returning 1ns after it.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
      MemWriteM  = we;
      ALUOutM    = {32'h0, addr};
      WriteDataM = data;
      @(posedge clk);
      #1;
      MemWriteM = 1'b0;
   endtask

   task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] expected);
      MemWriteM = 1'b0;
      ALUOutM   = {32'h0, addr};
      #1;
      checkOutput(tag, ReadDataM, expected);
   endtask

   initial begin
      reset      = 1'b1;
      MemWriteM  = 1'b0;
      ALUOutM    = '0;
      WriteDataM = '0;
      tx_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", 32'(tx_valid), 32'h0);
      checkOutput("reset_ovf", 32'(tx_overflow), 32'h0);
      reset = 1'b0;
      checkRead("reset_status", STAT, 32'h10);

      // RAM store/load, ignored address LSBs, unmapped addresses
      applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
      checkRead("ram_rd10", 32'h10, 32'hDEAD_BEEF);
      checkRead("ram_rd13", 32'h13, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 32'h0, 32'h1111_1111);
      applyStimulus(1'b1, 32'hFC, 32'h7777_7777);
      applyStimulus(1'b1, 32'h100, 32'h2222_2222);
      checkRead("ram_word0", 32'h0, 32'h1111_1111);
      checkRead("ram_topword", 32'hFC, 32'h7777_7777);
      checkRead("unmapped_rd", 32'h100, 32'h0);
      checkRead("txdata_rd", TX, 32'h0);
      checkRead("ctrl_rd", CTRL, 32'h0);

      // three pushes held back, then drained in order
      applyStimulus(1'b1, TX, 32'h41);
      checkOutput("push_latency", 32'(tx_valid), 32'h1);
      applyStimulus(1'b1, TX, 32'h42);
      applyStimulus(1'b1, TX, 32'h43);
      checkRead("status3", STAT, 32'h3);
      checkRead("status3_again", STAT, 32'h3);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("drain3", 32'(tx_data), 32'h41 + i);
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      checkOutput("drain3_empty", 32'(tx_valid), 32'h0);
      checkRead("drain3_status", STAT, 32'h10);

      // nine pushes into eight slots
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, TX, 32'h50 + i);
      checkRead("ovf_status", STAT, 32'h68);
      checkOutput("ovf_flag", 32'(tx_overflow), 32'h1);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain9", 32'(tx_data), 32'h50 + i);
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      checkOutput("drain9_empty", 32'(tx_valid), 32'h0);
      checkOutput("ovf_sticky", 32'(tx_overflow), 32'h1);
      applyStimulus(1'b1, CTRL, 32'h1);
      checkRead("ovf_cleared", STAT, 32'h10);

      // push against a full FIFO while it is also popping
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, TX, 32'h60 + i);
      checkRead("full_status", STAT, 32'h28);
      tx_ready = 1'b1;
      applyStimulus(1'b1, TX, 32'h99);
      tx_ready = 1'b0;
      checkOutput("fullpop_ovf", 32'(tx_overflow), 32'h1);
      checkOutput("fullpop_head", 32'(tx_data), 32'h61);
      checkRead("fullpop_status", STAT, 32'h47);
      tx_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         checkOutput("drain_fullpop", 32'(tx_data), 32'h60 + i);
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      checkOutput("fullpop_empty", 32'(tx_valid), 32'h0);
      applyStimulus(1'b1, CTRL, 32'h1);
      checkOutput("fullpop_clr", 32'(tx_overflow), 32'h0);

      // steady push+pop at count 2 across pointer wrap, then flush mid-drain
      applyStimulus(1'b1, TX, 32'h70);
      applyStimulus(1'b1, TX, 32'h71);
      for (int i = 0; i < 10; i++) begin
         tx_ready = 1'b1;
         checkOutput("wrap_order", 32'(tx_data), 32'h70 + i);
         applyStimulus(1'b1, TX, 32'h72 + i);
      end
      tx_ready = 1'b0;
      checkRead("wrap_status", STAT, 32'h2);
      checkOutput("wrap_head", 32'(tx_data), 32'h7A);
      tx_ready = 1'b1;
      applyStimulus(1'b1, CTRL, 32'h2);
      tx_ready = 1'b0;
      checkOutput("flush_valid", 32'(tx_valid), 32'h0);
      checkRead("flush_status", STAT, 32'h10);
      applyStimulus(1'b1, TX, 32'hAB);
      checkOutput("flush_push", 32'(tx_data), 32'hAB);
      applyStimulus(1'b1, CTRL, 32'h2);

      // reset with bytes queued; stores during reset are ignored
      applyStimulus(1'b1, 32'h20, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, TX, 32'hB0 + i);
      checkRead("prereset_status", STAT, 32'h5);
      reset    = 1'b1;
      tx_ready = 1'b1;
      applyStimulus(1'b1, 32'h20, 32'h0BAD_BAD0);
      reset    = 1'b0;
      tx_ready = 1'b0;
      checkOutput("postreset_valid", 32'(tx_valid), 32'h0);
      checkRead("postreset_status", STAT, 32'h10);
      checkRead("postreset_ram", 32'h20, 32'hCAFE_F00D);
      applyStimulus(1'b1, TX, 32'hC1);
      checkOutput("postreset_push", 32'(tx_data), 32'hC1);
      checkRead("postreset_count", STAT, 32'h1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets core data word width.
REQ-002 Parameter MEM_WORDS, default 64, sets number of RAM words (power of 2).
REQ-003 Parameter FIFO_DEPTH, default 8, sets TX FIFO entries (power of 2, at least 2).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port MemWriteM  input  1  store strobe from memory stage.
REQ-007 Port ALUOutM  input  2*DATA_WIDTH  address from memory stage; only bits [31:0] used.
REQ-008 Port WriteDataM  input  32  store data.
REQ-009 Port ReadDataM  output  32  load data, combinational from address.
REQ-010 Port tx_valid  output  1  FIFO head byte available.
REQ-011 Port tx_data  output  8  FIFO head byte.
REQ-012 Port tx_ready  input  1  consumer accepts head byte.
REQ-013 Port tx_overflow  output  1  sticky: a push was dropped.

Function
REQ-014 Address map, A = ALUOutM[31:0]: RAM at 0x0000_0000 to 4*MEM_WORDS-1; TXDATA 0xFFFF_0000; STATUS 0xFFFF_0004; CTRL 0xFFFF_0008; all other addresses unmapped.
REQ-015 RAM word index = A[log2(MEM_WORDS)+1:2]; A[1:0] ignored; word access only.
REQ-016 RAM read asynchronous: ReadDataM = RAM[index] in the same cycle the address is presented.
REQ-017 RAM write when MemWriteM=1 at a RAM address; new value visible to a read in the next cycle.
REQ-018 Reads have no side effects at any address; the block never pops or clears state on a read.
REQ-019 STATUS read value: bits[3:0] count, bit4 empty, bit5 full, bit6 overflow, bits[31:7] zero.
REQ-020 TXDATA, CTRL and unmapped reads return 0; unmapped writes are ignored.
REQ-021 A store to TXDATA is a push of WriteDataM[7:0]; accepted only when count < FIFO_DEPTH.
REQ-022 A push while full is dropped and sets tx_overflow in the next cycle, even if a pop occurs that same cycle.
REQ-023 tx_valid = (count != 0); tx_data = head entry; both registered-state derived, no combinational path from tx_ready.
REQ-024 Pop occurs when tx_valid and tx_ready are both 1; the head pointer advances mod FIFO_DEPTH.
REQ-025 Simultaneous accepted push and pop: count unchanged; both pointers advance.
REQ-026 Pop with tx_valid=0 is ignored; count never underflows.
REQ-027 Read and write pointers wrap from FIFO_DEPTH-1 to 0.
REQ-028 Store to CTRL, WriteDataM bit0=1: clears tx_overflow next cycle.
REQ-029 Store to CTRL, WriteDataM bit1=1: flush; count and pointers go to 0 next cycle, overriding any same-cycle pop.
REQ-030 Push-to-tx_valid latency is one cycle from an empty FIFO; FIFO order is strictly FIFO.

Reset
REQ-031 While reset=1, count, pointers and tx_overflow are 0 and all writes are ignored; tx_valid=0 in the cycle after reset is sampled.
REQ-032 RAM contents are not reset; software must not rely on initial values.
REQ-033 Reset mid-drain discards all queued bytes; no pop completes in the reset cycle.

Structure
REQ-034 Shared package holds the address constants TXDATA/STATUS/CTRL, STATUS bit positions and CTRL bit positions.
REQ-035 FIFO implemented as sub-module tx_fifo (push, pop, flush, count, full, empty, head); dmem_mmio holds decode, RAM and overflow flag.

Verification
REQ-036 Store 0xDEADBEEF to 0x10, then load 0x10 next cycle -> ReadDataM=0xDEADBEEF; load 0x13 -> same value.
REQ-037 Store 0x41,0x42,0x43 to TXDATA with tx_ready=0 -> STATUS=0x3; then tx_ready=1 -> tx_data 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0, STATUS=0x10.
REQ-038 Push 9 bytes with tx_ready=0 -> STATUS=0x68 (count 8, full, overflow); 9th byte absent from drain; CTRL write 0x1 -> overflow bit 0.
REQ-039 Fill FIFO, then push with tx_ready=1 in the same cycle -> push dropped, tx_overflow=1, count=7.
REQ-040 Drain across pointer wrap (12 pushes/pops interleaved at count 2) -> order preserved; CTRL write 0x2 mid-drain -> count 0 next cycle, tx_valid=0.
REQ-041 Assert reset with 5 bytes queued -> tx_valid=0, STATUS=0x10 after reset; RAM word written before reset still readable.
